// File: rtl/controle_entrada_switch_if.sv
// Handshake bundle between the board inputs, the control unit and the input controller.
// The slave modport is the controller side; the master modport drives the request, button and switches.
interface controle_entrada_switch_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  estagioEntradaUC;
  logic                  botao;
  logic [DATA_WIDTH-1:0] switches;
  logic [DATA_WIDTH-1:0] dadoSwitch;
  logic                  estagioEntradaSwitch;
  logic                  estagioEntradaBanco;
  logic                  aguardando;

  modport master (
    output estagioEntradaUC,
    output botao,
    output switches,
    input  dadoSwitch,
    input  estagioEntradaSwitch,
    input  estagioEntradaBanco,
    input  aguardando
  );

  modport slave (
    input  estagioEntradaUC,
    input  botao,
    input  switches,
    output dadoSwitch,
    output estagioEntradaSwitch,
    output estagioEntradaBanco,
    output aguardando
  );
endinterface

// File: rtl/controle_entrada_switch.sv
// Input-instruction handshake controller: synchronizes and debounces the confirm button,
// captures the switch word on a fresh press and emits the Switch/Banco handshake pulses.
module controle_entrada_switch #(
  parameter int DATA_WIDTH      = 16,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic                     clock,
  input  logic                     reset,
  controle_entrada_switch_if.slave bus
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] C_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE         = 3'd0,
    S_WAIT_PRESS   = 3'd1,
    S_CAPTURE      = 3'd2,
    S_WRITE        = 3'd3,
    S_WAIT_RELEASE = 3'd4
  } state_t;

  logic [1:0]            r_botao_sync;
  logic [DATA_WIDTH-1:0] r_sw_sync0;
  logic [DATA_WIDTH-1:0] r_sw_sync1;
  logic                  r_estavel;
  logic                  r_estavel_d;
  logic [CW-1:0]         r_cont;
  logic [DATA_WIDTH-1:0] r_dado;
  state_t                r_state;
  state_t                w_next_state;
  logic                  w_botao_s;
  logic                  w_pressao;
  logic                  w_load;

  assign w_botao_s = r_botao_sync[1];
  assign w_pressao = r_estavel & ~r_estavel_d;

  // Two-flop synchronizers for the button and the switch word
  always_ff @(posedge clock) begin
    if (reset) begin
      r_botao_sync <= 2'b00;
      r_sw_sync0   <= {DATA_WIDTH{1'b0}};
      r_sw_sync1   <= {DATA_WIDTH{1'b0}};
    end else begin
      r_botao_sync <= {r_botao_sync[0], bus.botao};
      r_sw_sync0   <= bus.switches;
      r_sw_sync1   <= r_sw_sync0;
    end
  end

  // Debouncer: accept a level change only after DEBOUNCE_CYCLES consecutive differing samples
  always_ff @(posedge clock) begin
    if (reset) begin
      r_estavel   <= 1'b0;
      r_estavel_d <= 1'b0;
      r_cont      <= {CW{1'b0}};
    end else begin
      r_estavel_d <= r_estavel;
      if (w_botao_s == r_estavel) begin
        r_cont <= {CW{1'b0}};
      end else if (r_cont == C_LAST) begin
        r_estavel <= ~r_estavel;
        r_cont    <= {CW{1'b0}};
      end else begin
        r_cont <= r_cont + CW'(1);
      end
    end
  end

  // State register and captured switch word
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_dado  <= {DATA_WIDTH{1'b0}};
    end else begin
      r_state <= w_next_state;
      if (w_load) begin
        r_dado <= r_sw_sync1;
      end else begin
        r_dado <= r_dado;
      end
    end
  end

  // Next-state logic; an abort in WAIT_PRESS wins over a simultaneous press
  always_comb begin
    w_next_state = r_state;
    w_load       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.estagioEntradaUC) w_next_state = S_WAIT_PRESS;
        else                      w_next_state = S_IDLE;
      end
      S_WAIT_PRESS: begin
        if (!bus.estagioEntradaUC) begin
          w_next_state = S_IDLE;
        end else if (w_pressao) begin
          w_next_state = S_CAPTURE;
          w_load       = 1'b1;
        end else begin
          w_next_state = S_WAIT_PRESS;
        end
      end
      S_CAPTURE:      w_next_state = S_WRITE;
      S_WRITE:        w_next_state = S_WAIT_RELEASE;
      S_WAIT_RELEASE: begin
        if (!r_estavel) w_next_state = S_IDLE;
        else            w_next_state = S_WAIT_RELEASE;
      end
      default:        w_next_state = S_IDLE;
    endcase
  end

  assign bus.dadoSwitch           = r_dado;
  assign bus.estagioEntradaSwitch = (r_state == S_CAPTURE);
  assign bus.estagioEntradaBanco  = (r_state == S_WRITE);
  assign bus.aguardando           = (r_state == S_WAIT_PRESS);

endmodule

// File: tb/tb_controle_entrada_switch.sv
// Scoreboard bench: stimulus queues the expected captured word, a negedge monitor checks each handshake.
module tb_controle_entrada_switch;

  logic clock;
  logic reset;
  int   n_checks;
  int   n_fail;
  int   n_caps;
  logic prev_sw;
  logic [15:0] exp_q[$];

  controle_entrada_switch_if #(.DATA_WIDTH(16)) bus ();

  controle_entrada_switch #(
    .DATA_WIDTH      (16),
    .DEBOUNCE_CYCLES (4)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic wait_caps(input int target, input int budget);
    int k;
    k = 0;
    while (n_caps < target && k < budget) begin
      tick(1);
      k++;
    end
    check("capture_within_budget", n_caps, target);
  endtask

  // Monitor: pops the scoreboard on every CAPTURE pulse and checks the Banco pulse that follows
  always @(negedge clock) begin
    logic [15:0] e;
    if (!reset) begin
      if (bus.estagioEntradaSwitch) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_capture: got dadoSwitch %h, expected no capture (t=%0t)", bus.dadoSwitch, $time);
        end else begin
          e = exp_q.pop_front();
          check("dadoSwitch_at_capture", bus.dadoSwitch, e);
        end
        check("banco_low_in_capture", bus.estagioEntradaBanco, 0);
        check("aguardando_low_in_capture", bus.aguardando, 0);
        n_caps++;
      end
      if (prev_sw) begin
        check("banco_after_switch", bus.estagioEntradaBanco, 1);
        check("switch_one_cycle", bus.estagioEntradaSwitch, 0);
      end else if (bus.estagioEntradaBanco) begin
        check("banco_without_switch", bus.estagioEntradaBanco, 0);
      end
    end
    prev_sw <= reset ? 1'b0 : bus.estagioEntradaSwitch;
  end

  initial begin
    int w;
    n_checks = 0;
    n_fail   = 0;
    n_caps   = 0;
    reset    = 1'b1;
    bus.estagioEntradaUC = 1'b0;
    bus.botao            = 1'b0;
    bus.switches         = 16'h0000;
    tick(2);
    reset = 1'b0;
    check("reset_aguardando", bus.aguardando, 0);
    check("reset_dado", bus.dadoSwitch, 0);
    check("reset_switch", bus.estagioEntradaSwitch, 0);
    check("reset_banco", bus.estagioEntradaBanco, 0);

    // Basic input with a clean 10-cycle press
    bus.switches = 16'hA5C3;
    tick(3);
    bus.estagioEntradaUC = 1'b1;
    tick(1);
    check("basic_aguardando_on_request", bus.aguardando, 1);
    exp_q.push_back(16'hA5C3);
    bus.botao = 1'b1;
    tick(5);
    check("basic_still_waiting", bus.aguardando, 1);
    tick(5);
    check("basic_capture_count", n_caps, 1);
    check("basic_aguardando_after", bus.aguardando, 0);
    bus.estagioEntradaUC = 1'b0;
    bus.botao = 1'b0;
    tick(10);
    check("basic_idle_after_release", bus.aguardando, 0);
    check("basic_dado_held", bus.dadoSwitch, 16'hA5C3);

    // Bounce rejection inside WAIT_PRESS
    bus.estagioEntradaUC = 1'b1;
    tick(1);
    check("bounce_waiting", bus.aguardando, 1);
    for (int i = 0; i < 5; i++) begin
      bus.botao = 1'b1;
      tick(2);
      bus.botao = 1'b0;
      tick(2);
    end
    tick(10);
    check("bounce_still_waiting", bus.aguardando, 1);
    check("bounce_dado_unchanged", bus.dadoSwitch, 16'hA5C3);
    check("bounce_no_capture", n_caps, 1);

    // Held button across two consecutive requests
    bus.switches = 16'h1234;
    tick(3);
    exp_q.push_back(16'h1234);
    bus.botao = 1'b1;
    wait_caps(2, 30);
    tick(3);
    bus.estagioEntradaUC = 1'b0;
    tick(1);
    bus.estagioEntradaUC = 1'b1;
    tick(15);
    check("held_stays_release", bus.aguardando, 0);
    bus.switches = 16'hBEEF;
    bus.botao = 1'b0;
    tick(12);
    check("held_waiting_after_release", bus.aguardando, 1);
    check("held_no_reuse", n_caps, 2);
    exp_q.push_back(16'hBEEF);
    bus.botao = 1'b1;
    wait_caps(3, 30);
    tick(2);
    bus.estagioEntradaUC = 1'b0;
    bus.botao = 1'b0;
    tick(12);
    check("held_second_dado", bus.dadoSwitch, 16'hBEEF);
    check("held_idle", bus.aguardando, 0);

    // Abort before any press
    bus.estagioEntradaUC = 1'b1;
    tick(1);
    check("abort_waiting", bus.aguardando, 1);
    bus.estagioEntradaUC = 1'b0;
    tick(1);
    check("abort_idle", bus.aguardando, 0);
    check("abort_no_switch", bus.estagioEntradaSwitch, 0);
    check("abort_no_banco", bus.estagioEntradaBanco, 0);
    tick(3);

    // Reset while in WRITE
    bus.switches = 16'h7777;
    tick(3);
    bus.estagioEntradaUC = 1'b1;
    exp_q.push_back(16'h7777);
    bus.botao = 1'b1;
    w = 0;
    while (!bus.estagioEntradaBanco && w < 30) begin
      tick(1);
      w++;
    end
    check("reset_mid_reached_write", bus.estagioEntradaBanco, 1);
    reset = 1'b1;
    bus.estagioEntradaUC = 1'b0;
    bus.botao = 1'b0;
    tick(1);
    reset = 1'b0;
    check("reset_mid_dado", bus.dadoSwitch, 0);
    check("reset_mid_aguardando", bus.aguardando, 0);
    check("reset_mid_switch", bus.estagioEntradaSwitch, 0);
    check("reset_mid_banco", bus.estagioEntradaBanco, 0);
    tick(10);

    // Press and release while IDLE must not be consumed later
    bus.switches = 16'h0F0F;
    bus.botao = 1'b1;
    tick(10);
    bus.botao = 1'b0;
    tick(10);
    bus.estagioEntradaUC = 1'b1;
    tick(15);
    check("outside_still_waiting", bus.aguardando, 1);
    check("outside_no_capture", n_caps, 4);
    exp_q.push_back(16'h0F0F);
    bus.botao = 1'b1;
    wait_caps(5, 30);
    tick(2);
    bus.estagioEntradaUC = 1'b0;
    bus.botao = 1'b0;
    tick(12);
    check("outside_dado", bus.dadoSwitch, 16'h0F0F);
    check("outside_idle", bus.aguardando, 0);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/controle_entrada_switch.md
# controle_entrada_switch

Input-handshake controller that sits directly upstream of the control unit for the input instruction (opcode 19). While the control unit requests input, it synchronizes and debounces the board's confirm button and captures the switch word on a clean press. It then drives the two handshake flags, `estagioEntradaSwitch` then `estagioEntradaBanco`, that release the PC stall. It also waits for the button to be released, so one press never satisfies two consecutive input instructions.

## Interface
- `DATA_WIDTH`, default 16: width of the switch word and captured data.
- `DEBOUNCE_CYCLES`, default 50000: consecutive stable samples required to accept a button level change. Must be ≥1. Counter width is clog2(DEBOUNCE_CYCLES)+1.

- `clock` input 1: single system clock. All state updates on the rising edge.
- `reset` input 1: one clock; reset is synchronous and active-high.
- `estagioEntradaUC` input 1: input request from the control unit, high while opcode 19 is executing.
- `botao` input 1: raw confirm button, asynchronous, active-high, bouncy.
- `switches` input DATA_WIDTH: raw board switches, asynchronous.
- `dadoSwitch` output DATA_WIDTH: captured switch word, feeds the register-file write-data mux.
- `estagioEntradaSwitch` output 1: high for exactly one cycle in CAPTURE.
- `estagioEntradaBanco` output 1: high for exactly one cycle in WRITE.
- `aguardando` output 1: high in WAIT_PRESS; drives the "waiting for input" LED.

## Operation
- **Synchronizers:** two-flop synchronizer on `botao` produces `botao_s`. Two-flop synchronizer on `switches` produces `sw_s`. All four flops reset to 0.
- **Debouncer:**
  - Registers `estavel` (reset 0) and `cont` (reset 0).
  - If `botao_s` == `estavel`: `cont` <= 0.
  - Else if `cont` == DEBOUNCE_CYCLES-1: `estavel` <= ~`estavel` and `cont` <= 0.
  - Else: `cont` <= `cont`+1.
- **Press event:** `pressao` = `estavel` & ~`estavel_d`, where `estavel_d` is `estavel` delayed one cycle (reset 0). `pressao` is combinational and high for one cycle.
- **FSM states:** IDLE, WAIT_PRESS, CAPTURE, WRITE, WAIT_RELEASE. Reset state is IDLE.
  - IDLE: if `estagioEntradaUC` → WAIT_PRESS, else stay.
  - WAIT_PRESS:
    - If `estagioEntradaUC` == 0 → IDLE (abort). Abort has priority over `pressao`.
    - Else if `pressao` → CAPTURE, and `dadoSwitch` <= `sw_s` on the same edge.
    - Else stay.
  - CAPTURE: unconditional → WRITE.
  - WRITE: unconditional → WAIT_RELEASE.
  - WAIT_RELEASE: if `estavel` == 0 → IDLE, else stay. `estagioEntradaUC` is ignored in this state.
- **Moore outputs:** `estagioEntradaSwitch`, `estagioEntradaBanco` and `aguardando` are decoded from registered state only. No combinational path from any input to these outputs.
- **`dadoSwitch`:** loads only on the WAIT_PRESS→CAPTURE transition and holds otherwise. Reset value is 0.
- **Press must be fresh:** a press whose debounced rising edge occurs outside WAIT_PRESS is never consumed. If the button is already held when the request arrives, it must be released (debounced) and pressed again.
- **Resulting PC behaviour:** in CAPTURE (Switch=1, Banco=0) the control unit still holds the PC. In WRITE (Banco=1) the PC advances.

## Timing
- **Reset values:** all outputs 0. State IDLE, `estavel`=0, `cont`=0, all synchronizer and delay flops 0. Reset mid-handshake (any state) returns to IDLE on the next edge with outputs 0. A held button then needs release and re-press.
- **Request to waiting:** `estagioEntradaUC` rising at edge E gives `aguardando`=1 from edge E+1.
- **Button latency:** `botao` held steadily high from before edge P:
  - `botao_s`=1 after edge P+1.
  - `estavel`=1 after edge P+1+DEBOUNCE_CYCLES.
  - CAPTURE is entered at the following edge.
  - WRITE one edge later, WAIT_RELEASE one edge after that.
- **Bounce rejection:** any `botao_s` glitch shorter than DEBOUNCE_CYCLES cycles resets `cont` and never toggles `estavel`.
- **Handshake pulses:** `estagioEntradaSwitch` and `estagioEntradaBanco` are each exactly one cycle wide, in consecutive cycles, never overlapping.

## Test plan
Bench uses DEBOUNCE_CYCLES=4, DATA_WIDTH=16.
- **Basic input:** reset; raise `estagioEntradaUC`; `switches`=16'hA5C3; clean `botao` pulse of 10 cycles → `aguardando`=1 until CAPTURE; `dadoSwitch`=16'hA5C3; `estagioEntradaSwitch` one cycle, then `estagioEntradaBanco` one cycle; IDLE after debounced release.
- **Bounce:** in WAIT_PRESS, toggle `botao` 1/0 every 2 cycles for 20 cycles, then hold 0 → no CAPTURE, `estavel` stays 0, `dadoSwitch` unchanged.
- **Held-button reuse:** press and hold through handshake 1; re-raise `estagioEntradaUC` while still held → stays in WAIT_RELEASE, then WAIT_PRESS after release; second capture only after a new press. Two separate presses give two captures with the two distinct switch values.
- **Abort:** enter WAIT_PRESS, drop `estagioEntradaUC` before any press → IDLE next edge, `aguardando`=0, both handshake flags never asserted.
- **Reset mid-handshake:** assert `reset` for one cycle while in WRITE → next edge all outputs 0, `dadoSwitch`=0, state IDLE.
- **Press outside request:** press and release while IDLE, then raise `estagioEntradaUC` → remains in WAIT_PRESS; no capture until a new press.
